bus_arbiter: RTL

Round-robin arbiter that generates the 2-bit driver-select code for the shared tri-state bus. Each bus driver instance is wired to this block's `sel` output and drives the bus only when `sel` equals its own code (1, 2 or 3). Code 0 means no driver is enabled. The arbiter takes request lines from the three drivers and grants exactly one of them at a time. It inserts a one-cycle bus-turnaround gap between owners so that two drivers are never enabled in the same cycle.

---
 rtl/bus_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter producing the registered driver-select code for a shared tri-state bus.
// Optional forced release after MAX_HOLD cycles is compiled in when ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [1:0] sel,
  output logic [2:0] grant,
  output logic       busy,
  output logic       timeout
);

  // Handshake: a master holds req[i] high for as long as it wants the bus; it owns
  // the bus while sel == i+1 (grant[i] high) and releases it by dropping req[i].
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [1:0] owner, owner_next;
  logic [1:0] last, last_next;
  logic [1:0] winner;
  logic       winner_vld;
  logic       owner_req;
  logic       hold_hit;
  logic       force_release;

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be within 2..255");
  end

  // Scan starts just after the previous winner, so the last owner is checked last.
  always_comb begin
    winner = 2'd0;
    case (last)
      2'd0: begin
        if (req[1])      winner = 2'd1;
        else if (req[2]) winner = 2'd2;
        else             winner = 2'd0;
      end
      2'd1: begin
        if (req[2])      winner = 2'd2;
        else if (req[0]) winner = 2'd0;
        else             winner = 2'd1;
      end
      default: begin
        if (req[0])      winner = 2'd0;
        else if (req[1]) winner = 2'd1;
        else             winner = 2'd2;
      end
    endcase
  end

  assign winner_vld = |req;
  assign owner_req  = |(req & grant);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;

  // Value HOLD_LAST means this is the MAX_HOLD-th cycle the owner has seen sel.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else if ((state_next == GRANT) && (state != GRANT)) begin
      hold_cnt <= 8'd0;
    end else if ((state == GRANT) && (hold_cnt != 8'hFF)) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign hold_hit = (hold_cnt >= HOLD_LAST);
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_next    = state;
    owner_next    = owner;
    last_next     = last;
    force_release = 1'b0;
    case (state)
      IDLE: begin
        if (winner_vld) begin
          state_next = GRANT;
          owner_next = winner;
          last_next  = winner;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_next = TURNAROUND;
        end else if (hold_hit) begin
          state_next    = TURNAROUND;
          force_release = 1'b1;
        end
      end
      TURNAROUND: begin
        if (winner_vld) begin
          state_next = GRANT;
          owner_next = winner;
          last_next  = winner;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 2'd0;
      last  <= 2'd2;
      sel   <= 2'd0;
      grant <= 3'b000;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      last  <= last_next;
      busy  <= (state_next != IDLE);
      if (state_next == GRANT) begin
        sel   <= owner_next + 2'd1;
        grant <= 3'(3'b001 << owner_next);
      end else begin
        sel   <= 2'd0;
        grant <= 3'b000;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= force_release;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
